irq_fifo_drain_ctrl: RTL
========================

// Module: irq_fifo_drain_ctrl
// PURPOSE
//  Sequencer that drains the NI interrupt FIFO pair (irq queue, data queue) on behalf of the core.
//  Watches the FIFO's irq_irq_sig / irq_data_sig, issues single-word config reads to offset 1 (irq) or 0 (data),
//  captures the 1-cycle-latency read data, and presents each entry as a valid/ready event stream.
//  Arbitrates irq vs data queue fairly and counts error responses. Sits between irq_fifo and the core IRQ unit.
// PARAMETERS
//  ADDR_W     14  config address width
//  ENTRY_W    14  FIFO entry width (rdata[ENTRY_W-1:0])
//  RR_EN      1   1: round-robin irq/data; 0: fixed priority, irq queue first
//  ERRCNT_W   8   width of saturating error counter
// PORTS
//  clk              in   1        clock
//  reset            in   1        synchronous, active-high reset
//  irq_pending      in   1        irq_irq_sig from FIFO (irq queue non-empty)
//  data_pending     in   1        irq_data_sig from FIFO (data queue non-empty)
//  cfg_sel          out  1        FIFO select
//  cfg_en           out  1        config access enable
//  cfg_wr           out  1        always 0 (read-only master)
//  cfg_addr         out  ADDR_W   0 = data queue, 1 = irq queue
//  cfg_wdata        out  32       always 0
//  cfg_rdata        in   32       FIFO read data, valid the cycle after the access
//  cfg_error        in   1        FIFO error, valid the cycle after the access
//  evt_valid        out  1        event available
//  evt_ready        in   1        consumer accepts event
//  evt_is_irq       out  1        1 = from irq queue, 0 = from data queue
//  evt_data         out  ENTRY_W  entry payload
//  enable           in   1        0: finish any in-flight access/event, then issue no new reads
//  busy             out  1        FSM not in IDLE
//  err_count        out  ERRCNT_W saturating count of cfg_error responses
// BEHAVIOUR
//  Reset: state=IDLE; cfg_sel/cfg_en/cfg_wr=0, cfg_addr=0, cfg_wdata=0; evt_valid=0, evt_is_irq=0, evt_data=0;
//   busy=0; err_count=0; rr_last=data (so first contested grant goes to irq). Reset mid-access aborts it.
//  FSM: IDLE -> ISSUE -> CAPTURE -> HOLD -> IDLE.
//   IDLE: if enable & (irq_pending|data_pending): choose queue, register grant, go ISSUE.
//    RR_EN=1: both pending -> queue opposite rr_last; one pending -> that queue. RR_EN=0: irq wins.
//   ISSUE (exactly 1 cycle): cfg_sel=cfg_en=1, cfg_wr=0, cfg_addr=grant?1:0. FIFO pops on this edge.
//   CAPTURE (1 cycle): sample cfg_rdata/cfg_error. error=1 -> err_count+1 (saturate at all-ones),
//    drop entry, go IDLE. Else latch evt_data=cfg_rdata[ENTRY_W-1:0], evt_is_irq=grant, evt_valid=1, go HOLD.
//    rr_last updated to grant in CAPTURE in both cases.
//   HOLD: evt_valid/evt_data/evt_is_irq stable until evt_valid&evt_ready; on that edge evt_valid=0, go IDLE.
//  Outputs registered; cfg_* driven only in ISSUE, all zero otherwise.
//  Latency: pending seen in IDLE -> evt_valid 3 cycles later. Max throughput 1 event / 4 cycles
//   (ready held high). pending flags are not re-sampled until IDLE, so the FIFO's post-pop flag update
//   never causes a read of an empty queue.
//  enable deasserted in ISSUE/CAPTURE/HOLD: current sequence completes normally; next IDLE stays idle.
//  Both pending low in IDLE: no access. evt_ready while evt_valid=0: ignored.
//  busy = (state != IDLE).
// STRUCTURE
//  Package irq_drain_pkg: state enum {IDLE,ISSUE,CAPTURE,HOLD}; localparams OFS_DATA=0, OFS_IRQ=1.
//  Sub-module irq_rr_arb2 (2-requester round-robin/fixed-priority arbiter with rr_last state),
//  instantiated once; FSM, capture registers and error counter in this module.
// TESTING (bench instantiates irq_fifo as DUT partner)
//  Push irq entry 0x0123, evt_ready=1 -> one ISSUE at addr 1; evt_valid 3 cycles after pending, evt_is_irq=1, evt_data=0x0123.
//  Push irq 0x0011,0x0012 and data 0x2001,0x2002 together, RR_EN=1 -> order irq 0x0011, data 0x2001,
//   irq 0x0012, data 0x2002; same with RR_EN=0 -> both irq first.
//  Entry arrives, evt_ready=0 for 10 cycles -> evt_valid held, evt_data stable, no further cfg_en;
//   ready=1 -> accepted, next read follows.
//  Force cfg_error=1 in CAPTURE -> no evt_valid, err_count 0->1; 256 errors with ERRCNT_W=8 -> saturates at 0xFF.
//  Drop enable during ISSUE -> that event still delivered, no further cfg_en while pending=1; re-enable -> draining resumes.
//  Assert reset in CAPTURE -> next cycle all outputs at reset values, err_count=0, busy=0.

Source files
------------

// File: rtl/irq_drain_pkg.sv
// ----------------------------------------------------------------------------
// irq_drain_pkg
//   Shared types and constants for the NI interrupt FIFO drain sequencer.
//   - drain_state_e : sequencer FSM states (IDLE -> ISSUE -> CAPTURE -> HOLD)
//   - OFS_DATA/OFS_IRQ : config offsets of the data / irq queue read ports
// ----------------------------------------------------------------------------
package irq_drain_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } drain_state_e;

    localparam int unsigned OFS_DATA = 0;
    localparam int unsigned OFS_IRQ  = 1;

endpackage

// File: rtl/irq_rr_arb2.sv
// ----------------------------------------------------------------------------
// irq_rr_arb2
//   Two-requester arbiter (irq queue vs data queue).
//   RR_EN=1: on contention grant the queue opposite to the last serviced one.
//   RR_EN=0: fixed priority, irq queue first.
// Ports
//   clk, reset      : clock, synchronous active-high reset (last = data)
//   req_irq_i       : irq queue requests service
//   req_data_i      : data queue requests service
//   upd_i           : record upd_irq_i as the last serviced queue
//   upd_irq_i       : 1 = irq queue was serviced, 0 = data queue
//   grant_valid_o   : at least one request present
//   grant_irq_o     : 1 = grant irq queue, 0 = grant data queue
// ----------------------------------------------------------------------------
module irq_rr_arb2 #(
    parameter int unsigned RR_EN = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic req_irq_i,
    input  logic req_data_i,
    input  logic upd_i,
    input  logic upd_irq_i,
    output logic grant_valid_o,
    output logic grant_irq_o
);

    // 1 = irq queue was serviced last, 0 = data queue
    logic rr_last_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last_q <= 1'b0;
        end else if (upd_i) begin
            rr_last_q <= upd_irq_i;
        end
    end

    always_comb begin
        grant_valid_o = req_irq_i | req_data_i;
        grant_irq_o   = req_irq_i;
        if (req_irq_i && req_data_i) begin
            grant_irq_o = (RR_EN != 0) ? ~rr_last_q : 1'b1;
        end
    end

endmodule

// File: rtl/irq_fifo_drain_ctrl.sv
// ----------------------------------------------------------------------------
// irq_fifo_drain_ctrl
//   Drains the NI interrupt FIFO pair (irq queue at offset 1, data queue at
//   offset 0) with single-word config reads and presents each entry as a
//   valid/ready event. Error responses drop the entry and bump a saturating
//   counter.
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   irq_pending           : irq queue non-empty
//   data_pending          : data queue non-empty
//   cfg_sel/cfg_en/cfg_wr : config access strobes (read-only master, wr=0)
//   cfg_addr              : 0 = data queue, 1 = irq queue
//   cfg_wdata             : always 0
//   cfg_rdata/cfg_error   : read response, valid the cycle after the access
//   evt_valid/evt_ready   : event handshake
//   evt_is_irq            : 1 = entry came from irq queue
//   evt_data              : entry payload
//   enable                : 0 = finish current sequence, then issue nothing
//   busy                  : sequencer not idle
//   err_count             : saturating count of error responses
// ----------------------------------------------------------------------------
module irq_fifo_drain_ctrl
    import irq_drain_pkg::*;
#(
    parameter int unsigned ADDR_W   = 14,
    parameter int unsigned ENTRY_W  = 14,
    parameter int unsigned RR_EN    = 1,
    parameter int unsigned ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                irq_pending,
    input  logic                data_pending,
    output logic                cfg_sel,
    output logic                cfg_en,
    output logic                cfg_wr,
    output logic [ADDR_W-1:0]   cfg_addr,
    output logic [31:0]         cfg_wdata,
    input  logic [31:0]         cfg_rdata,
    input  logic                cfg_error,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic                evt_is_irq,
    output logic [ENTRY_W-1:0]  evt_data,
    input  logic                enable,
    output logic                busy,
    output logic [ERRCNT_W-1:0] err_count
);

    drain_state_e        state_q, state_d;
    logic                grant_q, grant_d;
    logic                cfg_en_q, cfg_en_d;
    logic [ADDR_W-1:0]   cfg_addr_q, cfg_addr_d;
    logic                evt_valid_q, evt_valid_d;
    logic                evt_is_irq_q, evt_is_irq_d;
    logic [ENTRY_W-1:0]  evt_data_q, evt_data_d;
    logic [ERRCNT_W-1:0] err_count_q, err_count_d;

    logic arb_valid;
    logic arb_irq;
    logic rr_upd;

    // Only the low ENTRY_W bits of the read word carry the entry.
    logic unused_rdata_bits;
    assign unused_rdata_bits = ^cfg_rdata[31:ENTRY_W];

    irq_rr_arb2 #(
        .RR_EN (RR_EN)
    ) u_arb (
        .clk           (clk),
        .reset         (reset),
        .req_irq_i     (irq_pending),
        .req_data_i    (data_pending),
        .upd_i         (rr_upd),
        .upd_irq_i     (grant_q),
        .grant_valid_o (arb_valid),
        .grant_irq_o   (arb_irq)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            cfg_en_q     <= 1'b0;
            cfg_addr_q   <= '0;
            evt_valid_q  <= 1'b0;
            evt_is_irq_q <= 1'b0;
            evt_data_q   <= '0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            cfg_en_q     <= cfg_en_d;
            cfg_addr_q   <= cfg_addr_d;
            evt_valid_q  <= evt_valid_d;
            evt_is_irq_q <= evt_is_irq_d;
            evt_data_q   <= evt_data_d;
            err_count_q  <= err_count_d;
        end
    end

    // cfg_* are computed one state ahead so they are registered and high
    // exactly while the FSM sits in ISSUE.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        cfg_en_d     = 1'b0;
        cfg_addr_d   = '0;
        evt_valid_d  = evt_valid_q;
        evt_is_irq_d = evt_is_irq_q;
        evt_data_d   = evt_data_q;
        err_count_d  = err_count_q;
        rr_upd       = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable && arb_valid) begin
                    grant_d    = arb_irq;
                    cfg_en_d   = 1'b1;
                    cfg_addr_d = arb_irq ? ADDR_W'(OFS_IRQ) : ADDR_W'(OFS_DATA);
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                rr_upd = 1'b1;
                if (cfg_error) begin
                    if (err_count_q != '1) begin
                        err_count_d = err_count_q + ERRCNT_W'(1);
                    end
                    state_d = IDLE;
                end else begin
                    evt_data_d   = cfg_rdata[ENTRY_W-1:0];
                    evt_is_irq_d = grant_q;
                    evt_valid_d  = 1'b1;
                    state_d      = HOLD;
                end
            end
            HOLD: begin
                if (evt_ready) begin
                    evt_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cfg_sel    = cfg_en_q;
    assign cfg_en     = cfg_en_q;
    assign cfg_wr     = 1'b0;
    assign cfg_addr   = cfg_addr_q;
    assign cfg_wdata  = '0;
    assign evt_valid  = evt_valid_q;
    assign evt_is_irq = evt_is_irq_q;
    assign evt_data   = evt_data_q;
    assign busy       = (state_q != IDLE);
    assign err_count  = err_count_q;

endmodule
